// File: rtl/clken_synth_pkg.sv
// Shared definitions for the clock-enable synthesiser: lock state encoding
// and channel-index sizing constants.
package clken_synth_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/clken_synth_nco.sv
// One clock-enable channel: increment register, phase accumulator and a
// registered carry-out that marks each accumulator wrap.
module clken_synth_nco
    import clken_synth_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    output logic             carry
);

    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [ACC_W:0]   sum;

    // Accumulate modulo 2^ACC_W; a load restarts the phase from zero with the new increment.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc_q};
        inc_d   = inc_q;
        acc_d   = sum[ACC_W-1:0];
        carry_d = sum[ACC_W];
        if (load) begin
            inc_d   = load_inc;
            acc_d   = '0;
            carry_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            inc_q   <= inc_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;

endmodule

// File: rtl/clken_synth.sv
// Multi-channel phase-accumulator clock-enable synthesiser with a lock
// indicator that waits LOCK_CYCLES after every accepted reconfiguration.
// Optional feature: define CLKEN_SYNTH_SQUARE_OUT_EN to add a per-channel
// square-wave output (outclk) that toggles on each enable pulse.
module clken_synth
    import clken_synth_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CH-1:0]   outclk_en,
    output logic                locked
`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0]   outclk
`endif
);

    localparam int                CNT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CH_IDX_W:0] NUM_CH_LIM = NUM_CH[CH_IDX_W:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              ready_q, ready_d;
    logic              xfer;
    logic              cfg_hit;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] carry;

    // Out-of-range channel indices are accepted but change nothing.
    assign xfer    = cfg_valid & ready_q;
    assign cfg_hit = xfer & ({1'b0, cfg_ch} < NUM_CH_LIM);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_IDX_W-1:0] CH_ID = CH_IDX_W'(g);

        assign load[g] = cfg_hit & (cfg_ch == CH_ID);

        clken_synth_nco #(
            .ACC_W    (ACC_W)
        ) u_nco (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .load_inc (cfg_inc),
            .carry    (carry[g])
        );
    end

    // Lock sequencing: any real reconfiguration restarts the settle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b1;
        if (cfg_hit) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = LOCKED;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        locked_d = (state_d == LOCKED);
    end

    // Lock FSM registers with registered locked flag and config-ready flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
        end
    end

    assign cfg_ready = ready_q;
    assign locked    = locked_q;
    assign outclk_en = carry & {NUM_CH{locked_q}};

`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
    logic [NUM_CH-1:0] outclk_q, outclk_d;

    // Toggle on each visible enable pulse; reconfiguring a channel restarts it low.
    always_comb begin
        outclk_d = (outclk_q ^ outclk_en) & ~load;
    end

    // Square-wave output registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            outclk_q <= '0;
        end else begin
            outclk_q <= outclk_d;
        end
    end

    assign outclk = outclk_q;
`endif

endmodule

// File: tb/tb_clken_synth.sv
// Self-checking bench for clken_synth (NUM_CH=2, ACC_W=8, LOCK_CYCLES=16).
// Outputs are compared every cycle against a rate-based model; directed
// scenarios add literal expectations. CLKEN_SYNTH_SQUARE_OUT_EN adds outclk checks.
module tb_clken_synth;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;

    logic                refclk    = 1'b0;
    logic                rst_n     = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [2:0]          cfg_ch    = '0;
    logic [ACC_W-1:0]    cfg_inc   = '0;
    logic                cfg_ready;
    logic                locked;
    logic [NUM_CH-1:0]   outclk_en;
`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
    logic [NUM_CH-1:0]   outclk;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 refclk = ~refclk;

    clken_synth #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_inc     (cfg_inc),
        .outclk_en   (outclk_en),
        .locked      (locked)
`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
        ,
        .outclk      (outclk)
`endif
    );

    // Reference model: the pulse count after n cycles of phase growth is
    // floor(n*inc/2^ACC_W); a pulse appears whenever that count steps.
    longint m_cycles [NUM_CH] = '{default: 0};
    longint m_inc    [NUM_CH] = '{default: 0};
    int     m_toggles[NUM_CH] = '{default: 0};
    int     m_since           = 0;
    bit     m_ready           = 1'b0;

    function automatic bit m_locked();
        return m_since >= LOCK_CYCLES;
    endfunction

    function automatic bit m_raw(int ch);
        longint now_cnt, prev_cnt;
        if (m_cycles[ch] == 0) return 1'b0;
        now_cnt  = (m_cycles[ch] * m_inc[ch]) >> ACC_W;
        prev_cnt = ((m_cycles[ch] - 1) * m_inc[ch]) >> ACC_W;
        return now_cnt != prev_cnt;
    endfunction

    function automatic bit m_en(int ch);
        return m_raw(ch) && m_locked();
    endfunction

    // Advance the model on every rising edge, or clear it on reset.
    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cycles[ch]  = 0;
                m_inc[ch]     = 0;
                m_toggles[ch] = 0;
            end
            m_since = 0;
            m_ready = 1'b0;
        end else begin
            bit hit;
            hit = cfg_valid && m_ready && (int'(cfg_ch) < NUM_CH);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (m_en(ch)) m_toggles[ch]++;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (hit && int'(cfg_ch) == ch) begin
                    m_inc[ch]     = longint'(cfg_inc);
                    m_cycles[ch]  = 0;
                    m_toggles[ch] = 0;
                end else begin
                    m_cycles[ch]++;
                end
            end
            if (hit) m_since = 0;
            else if (m_since < LOCK_CYCLES) m_since++;
            m_ready = 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge refclk) begin
        check_output("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check_output("locked", 32'(locked), 32'(m_locked()));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check_output($sformatf("outclk_en[%0d]", ch), 32'(outclk_en[ch]), 32'(m_en(ch)));
`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
            check_output($sformatf("outclk[%0d]", ch), 32'(outclk[ch]), 32'(m_toggles[ch] % 2));
`endif
        end
    end

    task automatic apply_stimulus(input logic [2:0] ch, input logic [ACC_W-1:0] inc);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (!locked && n < 200) begin
            @(negedge refclk);
            n++;
        end
    endtask

    task automatic measure_gap(input int ch, output int gap);
        int n;
        n = 0;
        while (!outclk_en[ch] && n < 64) begin
            @(negedge refclk);
            n++;
        end
        @(negedge refclk);
        gap = 1;
        while (!outclk_en[ch] && gap < 64) begin
            @(negedge refclk);
            gap++;
        end
    endtask

    initial begin
        int n, gap, low, pulses;
        bit en_seen;

        repeat (3) @(negedge refclk);
        check_output("reset_cfg_ready", 32'(cfg_ready), 32'd0);
        check_output("reset_locked", 32'(locked), 32'd0);
        check_output("reset_outclk_en", 32'(outclk_en), 32'd0);
        rst_n = 1'b1;
        @(negedge refclk);
        check_output("ready_after_release", 32'(cfg_ready), 32'd1);

        // ch0 at quarter rate, ch1 at half rate
        apply_stimulus(3'd0, 8'h40);
        apply_stimulus(3'd1, 8'h80);
        wait_locked(n);
        check_output("lock_after_cfg", 32'(n), 32'd16);
        measure_gap(0, gap);
        check_output("ch0_gap_0x40", 32'(gap), 32'd4);
        measure_gap(1, gap);
        check_output("ch1_gap_0x80", 32'(gap), 32'd2);

        // reprogram ch1 to eighth rate
        apply_stimulus(3'd1, 8'h20);
        wait_locked(n);
        check_output("relock_ch1", 32'(n), 32'd16);
        measure_gap(1, gap);
        check_output("ch1_gap_0x20", 32'(gap), 32'd8);
        measure_gap(0, gap);
        check_output("ch0_gap_undisturbed", 32'(gap), 32'd4);

        // two transfers five cycles apart
        apply_stimulus(3'd0, 8'h40);
        low = 0;
        en_seen = 1'b0;
        while (!locked && low < 100) begin
            if (outclk_en != '0) en_seen = 1'b1;
            low++;
            cfg_valid = (low == 5);
            @(negedge refclk);
        end
        cfg_valid = 1'b0;
        check_output("double_cfg_low_cycles", 32'(low), 32'd21);
        check_output("double_cfg_no_pulses", 32'(en_seen), 32'd0);

        // out-of-range channel is ignored
        apply_stimulus(3'd7, 8'h10);
        low = 0;
        repeat (20) begin
            if (!locked) low++;
            @(negedge refclk);
        end
        check_output("ch7_keeps_lock", 32'(low), 32'd0);
        measure_gap(0, gap);
        check_output("ch7_ch0_gap", 32'(gap), 32'd4);
        measure_gap(1, gap);
        check_output("ch7_ch1_gap", 32'(gap), 32'd8);

        // one-cycle reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_locked", 32'(locked), 32'd0);
        check_output("midreset_ready", 32'(cfg_ready), 32'd0);
        check_output("midreset_outclk_en", 32'(outclk_en), 32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
        wait_locked(n);
        check_output("relock_after_reset", 32'(n), 32'd16);
        pulses = 0;
        repeat (40) begin
            if (outclk_en != '0) pulses++;
            @(negedge refclk);
        end
        check_output("no_pulses_inc0", 32'(pulses), 32'd0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cfg_valid = (r < 3);
            cfg_ch    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            cfg_inc   = 8'($urandom);
            if (r == 99 && $urandom_range(0, 3) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge refclk);
                rst_n = 1'b1;
            end else begin
                @(negedge refclk);
            end
        end
        cfg_valid = 1'b0;

`ifdef CLKEN_SYNTH_SQUARE_OUT_EN
        begin
            logic prev;
            #2 rst_n = 1'b0;
            @(negedge refclk);
            rst_n = 1'b1;
            @(negedge refclk);
            apply_stimulus(3'd0, 8'h40);
            wait_locked(n);
            n = 0;
            prev = outclk[0];
            while (outclk[0] == prev && n < 64) begin
                @(negedge refclk);
                n++;
            end
            prev = outclk[0];
            gap = 0;
            while (outclk[0] == prev && gap < 64) begin
                @(negedge refclk);
                gap++;
            end
            check_output("square_half_period", 32'(gap), 32'd4);
        end
`endif

        @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clken_synth.md
CLKEN_SYNTH -- requirements
Module: clken_synth

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent clock-enable channels (1..8).
REQ-002 Parameter ACC_W, default 32, phase-accumulator width in bits (8..32).
REQ-003 Parameter LOCK_CYCLES, default 16, settle cycles before locked asserts (>=1).
REQ-004 refclk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration request.
REQ-007 cfg_ready  output  1  configuration accept; transfer occurs when cfg_valid and cfg_ready are both high.
REQ-008 cfg_ch  input  3  target channel index.
REQ-009 cfg_inc  input  ACC_W  new phase increment for cfg_ch.
REQ-010 outclk_en  output  NUM_CH  per-channel one-cycle enable pulses.
REQ-011 locked  output  1  all channels configured and settled.

Function
REQ-012 Each channel SHALL hold an ACC_W-bit increment register and an ACC_W-bit accumulator.
REQ-013 Each cycle, each accumulator SHALL add its increment modulo 2^ACC_W; the carry-out SHALL be registered into outclk_en[ch], giving one cycle of latency.
REQ-014 Average pulse rate SHALL be f_refclk * inc / 2^ACC_W; inc=0 SHALL never pulse; inc=2^ACC_W-1 SHALL pulse on all but one cycle in 2^ACC_W.
REQ-015 A state machine SHALL have states SETTLE and LOCKED; reset enters SETTLE with the settle counter at 0.
REQ-016 In SETTLE, the counter SHALL increment each cycle; on reaching LOCK_CYCLES-1, the state SHALL go to LOCKED the next cycle.
REQ-017 locked SHALL be 1 exactly when the state is LOCKED; outclk_en SHALL be forced to 0 while not locked.
REQ-018 cfg_ready SHALL be 1 in both states.
REQ-019 A transfer SHALL load cfg_inc into the channel register, clear that channel's accumulator, clear the settle counter, and enter SETTLE on the next cycle.
REQ-020 A transfer arriving during SETTLE SHALL restart the settle count from 0.
REQ-021 A transfer with cfg_ch >= NUM_CH SHALL be accepted and ignored, with no state change and no effect on locked.
REQ-022 Channels not addressed by a transfer SHALL keep accumulating undisturbed.

Reset
REQ-023 On rst_n low, all increments SHALL be 0, all accumulators 0, outclk_en 0, locked 0, cfg_ready 0, state SETTLE, settle counter 0.
REQ-024 Reset asserted mid-operation SHALL take effect immediately and discard in-flight configuration.
REQ-025 Deassertion SHALL be synchronised to refclk by the integrating top level.
REQ-026 cfg_ready SHALL rise on the first refclk edge after reset release.

Configuration
REQ-027 Macro CLKEN_SYNTH_SQUARE_OUT_EN, when defined, SHALL add an output outclk [NUM_CH].
REQ-028 With the macro, each outclk bit SHALL toggle on every outclk_en pulse of its channel and SHALL reset to 0.
REQ-029 With the macro, an outclk bit SHALL be cleared when its channel is reconfigured.
REQ-030 Without the macro, the outclk port and its logic SHALL be absent.

Structure
REQ-031 Package clken_synth_pkg SHALL hold the state enum (SETTLE, LOCKED) and the constants MAX_CH=8 and CH_IDX_W=3.
REQ-032 The per-channel accumulator plus carry register SHALL be a sub-module clken_synth_nco, instantiated NUM_CH times with a generate loop.

Verification
REQ-033 ACC_W=8, ch0 inc=0x40: after locked rises, outclk_en[0] SHALL pulse every 4th cycle.
REQ-034 Ch1 inc=0x80 alongside ch0 inc=0x40: ch1 SHALL pulse every 2 cycles; reprogramming ch1 to 0x20 SHALL drop locked for 16 cycles, after which ch1 SHALL pulse every 8 cycles.
REQ-035 Two transfers 5 cycles apart SHALL keep locked low for 5+16 cycles, and outclk_en SHALL be 0 throughout.
REQ-036 A transfer with cfg_ch=7 and NUM_CH=2 SHALL leave locked and all pulses unchanged.
REQ-037 rst_n pulled low for 1 cycle mid-run SHALL zero all outputs immediately; with inc then 0, no pulses SHALL appear after relock.
REQ-038 With CLKEN_SYNTH_SQUARE_OUT_EN defined and inc=0x40 (ACC_W=8), outclk[0] SHALL be a square wave with period 8 cycles.
